// File: rtl/mor1kx_branch_resolution_unit.sv
// Resolve side of the gshare branch predictor: queues decode-time predictions,
// checks them against the real flag in execute, and reports updates/redirects.
module mor1kx_branch_resolution_unit #(
  parameter int GSHARE_BITS_NUM      = 10,
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int QUEUE_DEPTH          = 4,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pred_valid_i,
  input  logic                            pred_op_bf_i,
  input  logic                            pred_taken_i,
  input  logic [GSHARE_BITS_NUM-1:0]      pred_idx_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] pred_pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] pred_target_i,
  output logic                            pred_ready_o,
  input  logic                            resolve_valid_i,
  input  logic                            resolve_flag_i,
  input  logic                            flush_i,
  output logic                            update_valid_o,
  output logic [GSHARE_BITS_NUM-1:0]      update_idx_o,
  output logic                            update_taken_o,
  output logic [GSHARE_BITS_NUM-1:0]      hist_o,
  output logic                            mispredict_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
  output logic [CNT_WIDTH-1:0]            branch_cnt_o,
  output logic [CNT_WIDTH-1:0]            mispredict_cnt_o,
  output logic                            err_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int OW    = OPTION_OPERAND_WIDTH;
  localparam int GB    = GSHARE_BITS_NUM;

  typedef struct packed {
    logic          op_bf;
    logic          taken;
    logic [GB-1:0] idx;
    logic [OW-1:0] pc;
    logic [OW-1:0] target;
  } entry_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  entry_t               slot_q [QUEUE_DEPTH];
  entry_t               slot_d [QUEUE_DEPTH];
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;

  logic                 update_valid_q, update_valid_d;
  logic [GB-1:0]        update_idx_q, update_idx_d;
  logic                 update_taken_q, update_taken_d;
  logic [GB-1:0]        hist_q, hist_d;
  logic                 mispredict_q, mispredict_d;
  logic [OW-1:0]        redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;
  logic                 err_q, err_d;

  logic                 full, empty;
  entry_t               head;
  logic                 resolve_ok, actual, mispredict, push_ok, push_err, pop_err;

  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = slot_q[rd_ptr_q[PTR_W-1:0]];

  // A resolve must find an entry already queued; a same-cycle push cannot satisfy it.
  assign resolve_ok = resolve_valid_i && !empty && !flush_i;
  assign actual     = head.op_bf ? resolve_flag_i : !resolve_flag_i;
  assign mispredict = resolve_ok && (actual != head.taken);

  // Pushes in a mispredict cycle are wrong-path and silently dropped.
  assign push_ok  = pred_valid_i && !flush_i && !mispredict && (!full || resolve_ok);
  assign push_err = pred_valid_i && !flush_i && !mispredict && full && !resolve_ok;
  assign pop_err  = resolve_valid_i && empty && !flush_i;

  assign pred_ready_o = !full || resolve_valid_i;

  always_comb begin
    slot_d = slot_q;
    if (push_ok) begin
      slot_d[wr_ptr_q[PTR_W-1:0]] = '{op_bf:  pred_op_bf_i,
                                      taken:  pred_taken_i,
                                      idx:    pred_idx_i,
                                      pc:     pred_pc_i,
                                      target: pred_target_i};
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(resolve_ok);
    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push_ok);
    if (mispredict) begin
      wr_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
    if (flush_i) begin
      wr_ptr_d = rd_ptr_q;
    end
  end

  always_comb begin
    update_valid_d   = resolve_ok;
    mispredict_d     = mispredict;
    update_idx_d     = update_idx_q;
    update_taken_d   = update_taken_q;
    redirect_pc_d    = redirect_pc_q;
    hist_d           = hist_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    err_d            = err_q | push_err | pop_err;
    if (resolve_ok) begin
      update_idx_d   = head.idx;
      update_taken_d = actual;
      // Not-taken path skips the delay slot.
      redirect_pc_d  = actual ? head.target : head.pc + OW'(8);
      hist_d         = {hist_q[GB-2:0], actual};
      branch_cnt_d   = sat_inc(branch_cnt_q);
      if (mispredict) begin
        mispredict_cnt_d = sat_inc(mispredict_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  // Resolve-stage result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      update_valid_q   <= 1'b0;
      update_idx_q     <= '0;
      update_taken_q   <= 1'b0;
      hist_q           <= '0;
      mispredict_q     <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      err_q            <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      update_valid_q   <= update_valid_d;
      update_idx_q     <= update_idx_d;
      update_taken_q   <= update_taken_d;
      hist_q           <= hist_d;
      mispredict_q     <= mispredict_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      err_q            <= err_d;
    end
  end

  assign update_valid_o   = update_valid_q;
  assign update_idx_o     = update_idx_q;
  assign update_taken_o   = update_taken_q;
  assign hist_o           = hist_q;
  assign mispredict_o     = mispredict_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_mor1kx_branch_resolution_unit.sv
// Scoreboard bench for the branch resolution unit: directed scenarios followed by
// random traffic, checked against a queue-based reference model.
module tb_mor1kx_branch_resolution_unit;

  localparam int GB = 10;
  localparam int OW = 32;
  localparam int QD = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pred_valid_i = 1'b0, pred_op_bf_i = 1'b0, pred_taken_i = 1'b0;
  logic [GB-1:0] pred_idx_i = '0;
  logic [OW-1:0] pred_pc_i = '0, pred_target_i = '0;
  logic          pred_ready_o;
  logic          resolve_valid_i = 1'b0, resolve_flag_i = 1'b0, flush_i = 1'b0;
  logic          update_valid_o, update_taken_o, mispredict_o, err_o;
  logic [GB-1:0] update_idx_o, hist_o;
  logic [OW-1:0] redirect_pc_o;
  logic [CW-1:0] branch_cnt_o, mispredict_cnt_o;

  mor1kx_branch_resolution_unit #(
    .GSHARE_BITS_NUM(GB), .OPTION_OPERAND_WIDTH(OW), .QUEUE_DEPTH(QD), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .pred_valid_i(pred_valid_i), .pred_op_bf_i(pred_op_bf_i), .pred_taken_i(pred_taken_i),
    .pred_idx_i(pred_idx_i), .pred_pc_i(pred_pc_i), .pred_target_i(pred_target_i),
    .pred_ready_o(pred_ready_o),
    .resolve_valid_i(resolve_valid_i), .resolve_flag_i(resolve_flag_i), .flush_i(flush_i),
    .update_valid_o(update_valid_o), .update_idx_o(update_idx_o),
    .update_taken_o(update_taken_o), .hist_o(hist_o),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          bf;
    logic          tk;
    logic [GB-1:0] idx;
    logic [OW-1:0] pc;
    logic [OW-1:0] tgt;
  } ent_t;

  typedef struct {
    int            due;
    logic [GB-1:0] idx;
    logic          tk;
    logic          mp;
    logic [OW-1:0] rpc;
    logic [GB-1:0] hist;
    logic [CW-1:0] bc;
    logic [CW-1:0] mc;
  } exp_t;

  ent_t          mq[$];
  exp_t          sb[$];
  logic [GB-1:0] m_hist = '0;
  int            m_bc = 0, m_mc = 0;
  logic          m_err = 1'b0;
  int            cyc = 0;
  int            n_vec = 0, n_err = 0;
  bit            mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("missing_update", 64'(cyc), 64'(sb[0].due));
        void'(sb.pop_front());
      end
      if (update_valid_o) begin
        if (sb.size() == 0 || sb[0].due != cyc) begin
          chk("unexpected_update", 64'(update_valid_o), 64'd0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("update_idx", 64'(update_idx_o), 64'(x.idx));
          chk("update_taken", 64'(update_taken_o), 64'(x.tk));
          chk("mispredict", 64'(mispredict_o), 64'(x.mp));
          chk("hist", 64'(hist_o), 64'(x.hist));
          chk("branch_cnt", 64'(branch_cnt_o), 64'(x.bc));
          chk("mispredict_cnt", 64'(mispredict_cnt_o), 64'(x.mc));
          if (x.mp) chk("redirect_pc", 64'(redirect_pc_o), 64'(x.rpc));
        end
      end else if (mispredict_o) begin
        chk("stray_mispredict", 64'(mispredict_o), 64'd0);
      end
    end
  end

  // One clock of stimulus; the reference model advances alongside the DUT.
  task automatic drive(input logic pv, input logic bf, input logic tk,
                       input logic [GB-1:0] idx, input logic [OW-1:0] pc,
                       input logic [OW-1:0] tgt, input logic rv, input logic fg,
                       input logic fl, input logic r);
    ent_t e;
    exp_t x;
    logic act, mp, full, rok;
    pred_valid_i = pv; pred_op_bf_i = bf; pred_taken_i = tk; pred_idx_i = idx;
    pred_pc_i = pc; pred_target_i = tgt; resolve_valid_i = rv; resolve_flag_i = fg;
    flush_i = fl; rst = r;
    #1;
    chk("pred_ready", 64'(pred_ready_o), 64'((mq.size() != QD) || rv));
    mp = 1'b0;
    if (r) begin
      mq.delete(); m_hist = '0; m_bc = 0; m_mc = 0; m_err = 1'b0;
    end else if (fl) begin
      mq.delete();
    end else begin
      full = (mq.size() == QD);
      rok  = rv && (mq.size() > 0);
      if (rv && !rok) m_err = 1'b1;
      if (rok) begin
        e = mq.pop_front();
        act = e.bf ? fg : !fg;
        mp = (act != e.tk);
        m_hist = GB'((m_hist * 2) + act);
        if (m_bc < (1 << CW) - 1) m_bc++;
        if (mp && m_mc < (1 << CW) - 1) m_mc++;
        x.due = cyc + 1; x.idx = e.idx; x.tk = act; x.mp = mp;
        x.rpc = act ? e.tgt : e.pc + 32'd8;
        x.hist = m_hist; x.bc = CW'(m_bc); x.mc = CW'(m_mc);
        sb.push_back(x);
        if (mp) mq.delete();
      end
      if (pv && !mp) begin
        if (full && !rok) m_err = 1'b1;
        else mq.push_back('{bf, tk, idx, pc, tgt});
      end
    end
    @(posedge clk);
    #1;
    chk("err", 64'(err_o), 64'(m_err));
    if (r) begin
      chk("rst_hist", 64'(hist_o), 64'd0);
      chk("rst_bcnt", 64'(branch_cnt_o), 64'd0);
      chk("rst_mcnt", 64'(mispredict_cnt_o), 64'd0);
      chk("rst_upd", 64'(update_valid_o), 64'd0);
    end
  endtask

  task automatic push(input logic bf, input logic tk, input logic [GB-1:0] idx,
                      input logic [OW-1:0] pc, input logic [OW-1:0] tgt);
    drive(1'b1, bf, tk, idx, pc, tgt, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic res(input logic fg);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, fg, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", 64'(pred_ready_o), 64'd1);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_redirect", 64'(redirect_pc_o), 64'd0);
    chk("rst_mispredict", 64'(mispredict_o), 64'd0);
    mon_en = 1'b1;

    // Correctly predicted l.bf
    push(1'b1, 1'b1, 10'h155, 32'h0000_2000, 32'h0000_3000);
    res(1'b1);
    chk("t1_valid", 64'(update_valid_o), 64'd1);
    chk("t1_idx", 64'(update_idx_o), 64'h155);
    chk("t1_taken", 64'(update_taken_o), 64'd1);
    chk("t1_mp", 64'(mispredict_o), 64'd0);
    chk("t1_hist", 64'(hist_o), 64'h001);
    chk("t1_bcnt", 64'(branch_cnt_o), 64'd1);

    // Mispredicted l.bnf: redirect to pc+8
    push(1'b0, 1'b1, 10'h0AA, 32'h0000_1000, 32'h0000_5000);
    res(1'b1);
    chk("t2_mp", 64'(mispredict_o), 64'd1);
    chk("t2_redirect", 64'(redirect_pc_o), 64'h1008);
    chk("t2_taken", 64'(update_taken_o), 64'd0);
    chk("t2_mcnt", 64'(mispredict_cnt_o), 64'd1);

    // pc+8 wraps around the address space
    push(1'b0, 1'b1, 10'h001, 32'hFFFF_FFFC, 32'h0000_0100);
    res(1'b1);
    chk("wrap_redirect", 64'(redirect_pc_o), 64'h4);

    // Fill, overflow, push+pop while full
    do_reset();
    for (int i = 0; i < QD; i++) push(1'b1, 1'b1, GB'(i), 32'h100 + 32'(i * 4), 32'h800);
    push(1'b1, 1'b1, 10'h3FF, 32'h200, 32'h900);
    chk("fill_err", 64'(err_o), 64'd1);
    drive(1'b1, 1'b1, 1'b1, 10'h3F0, 32'h300, 32'hA00, 1'b1, 1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b1, 10'h3F1, 32'h304, 32'hA00);
    for (int i = 0; i < QD + 1; i++) res(1'b1);

    // Squash: head mispredicts with a same-cycle push
    do_reset();
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, GB'(i + 8), 32'h400 + 32'(i * 4), 32'hC00);
    drive(1'b1, 1'b1, 1'b1, 10'h077, 32'h500, 32'hD00, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("squash_err", 64'(err_o), 64'd0);
    res(1'b1);
    chk("squash_empty_err", 64'(err_o), 64'd1);

    // Flush with a same-cycle resolve
    do_reset();
    push(1'b1, 1'b1, 10'h011, 32'h600, 32'hE00);
    res(1'b1);
    push(1'b1, 1'b1, 10'h022, 32'h604, 32'hE00);
    drive(1'b1, 1'b0, 1'b0, 10'h033, 32'h608, 32'hE00, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_hist", 64'(hist_o), 64'h001);
    chk("flush_bcnt", 64'(branch_cnt_o), 64'd1);
    res(1'b1);
    chk("flush_empty_err", 64'(err_o), 64'd1);

    // Saturation: 20 mispredicts on 4-bit counters
    do_reset();
    for (int i = 0; i < 20; i++) begin
      push(1'b0, 1'b1, GB'(i), 32'h700, 32'hF00);
      res(1'b1);
    end
    chk("sat_bcnt", 64'(branch_cnt_o), 64'hF);
    chk("sat_mcnt", 64'(mispredict_cnt_o), 64'hF);

    // Random traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic pv, rv, fl, r;
      pv = ($urandom_range(0, 9) < 6);
      if (mq.size() == 0) rv = ($urandom_range(0, 19) == 0);
      else rv = ($urandom_range(0, 1) == 1);
      if (mq.size() == QD && !rv && $urandom_range(0, 9) != 0) pv = 1'b0;
      fl = ($urandom_range(0, 39) == 0);
      r  = ($urandom_range(0, 99) == 0);
      drive(pv, 1'($urandom), 1'($urandom), GB'($urandom), $urandom, $urandom,
            rv, 1'($urandom), fl, r);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
